if_fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I pipeline. It owns the fetch PC, issues word requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned words in a small in-order FIFO. It presents `if_pc`/`if_inst` to the IF/ID pipeline register and redirects on taken branches or jumps resolved in ID or EX. When no instruction is ready, it drives a zero bubble and requests a pipeline stall.

---
 rtl/if_fetch_unit.sv | 107 ++++++++++
 tb/tb_if_fetch_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// RV32I instruction fetch stage: owns the fetch PC, issues req/gnt/rvalid word
// requests and buffers returned words in an in-order FIFO for the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        ex_b_flag,
    input  logic [31:0] ex_b_addr,
    input  logic        id_b_flag,
    input  logic [31:0] id_b_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_inst [DEPTH];
    logic [31:0]   addr_q    [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, aq_rd, aq_wr;
    logic [CW-1:0] count, inflight, drop_cnt, live;
    logic [CW:0]   occupancy;
    logic [31:0]   target;
    logic          redir, pop, push, grant;
    logic          unused_stall;

    assign redir  = ex_b_flag | id_b_flag;
    assign target = {(ex_b_flag ? ex_b_addr[31:2] : id_b_addr[31:2]), 2'b00};
    assign pop    = !stall[1] && (count != '0) && !redir;
    assign live   = inflight - drop_cnt;

    // Credit: live responses plus buffered words after this cycle's pop must leave
    // room, so every live response is guaranteed a FIFO slot when it returns.
    assign occupancy = {1'b0, live} + {1'b0, count} - (CW + 1)'(pop);
    assign imem_req  = !rst && !stall[0] && !redir &&
                       (inflight < DEPTH_C) && (occupancy < DEPTH_W);
    assign grant     = imem_req & imem_gnt;
    assign push      = imem_rvalid && (drop_cnt == '0) && !redir;

    assign imem_addr    = fetch_pc;
    assign if_pc        = (count != '0) ? fifo_pc[rd_ptr]   : 32'h0;
    assign if_inst      = (count != '0) ? fifo_inst[rd_ptr] : 32'h0;
    assign stallreq_if  = (count == '0);
    assign unused_stall = ^stall[5:2];

    // Control state; a redirect flushes the FIFO and marks every live in-flight
    // response stale (the one returning this very cycle is already gone).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            aq_rd    <= '0;
            aq_wr    <= '0;
            count    <= '0;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight + CW'(grant) - CW'(imem_rvalid);
            if (grant)
                aq_wr <= aq_wr + PW'(1);
            if (imem_rvalid)
                aq_rd <= aq_rd + PW'(1);
            if (redir) begin
                fetch_pc <= target;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                drop_cnt <= inflight - CW'(imem_rvalid);
            end else begin
                if (grant)
                    fetch_pc <= fetch_pc + 32'd4;
                if (imem_rvalid && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CW'(1);
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: the counters above decide which entries are valid.
    always_ff @(posedge clk) begin
        if (grant)
            addr_q[aq_wr] <= fetch_pc;
        if (push) begin
            fifo_pc[wr_ptr]   <= addr_q[aq_rd];
            fifo_inst[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order memory model with random latency and a
// program-order reference of what the fetch stage should present.
module tb_if_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        ex_b_flag, id_b_flag;
    logic [31:0] ex_b_addr, id_b_addr;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] if_pc, if_inst;
    logic        stallreq_if;

    if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .ex_b_flag(ex_b_flag), .ex_b_addr(ex_b_addr),
        .id_b_flag(id_b_flag), .id_b_addr(id_b_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_pc(if_pc), .if_inst(if_inst), .stallreq_if(stallreq_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_pops = 0;

    logic [5:0]  stall_v = '0;
    logic        ex_f = 1'b0, id_f = 1'b0;
    logic [31:0] ex_a = '0, id_a = '0;
    int          gnt_mode = 1;
    int          lat_min = 1, lat_max = 1;

    logic [31:0] exp_fetch, exp_pc;
    int          buf_n;
    logic [31:0] mq_addr [$];
    int          mq_rdy [$];
    bit          mq_stale [$];
    int          last_rdy;

    logic        s_req, s_stallreq;
    logic [31:0] s_addr, s_pc, s_inst;
    logic [31:0] pc0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F13;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $display("[TB] FAIL %s: observed %h required %h (cycle %0d)", tag, obs, exp_v, cyc);
            $error("[TB] check %s failed", tag);
        end
    endtask

    // One clock cycle: drive inputs, check the DUT against the model, then advance the model.
    task automatic applyStimulus();
        logic        redir, pop, grant, rsp_stale;
        logic [31:0] tgt;
        int          live, r;
        bit          exp_req, exp_empty;
        stall       = stall_v;
        ex_b_flag   = ex_f;
        ex_b_addr   = ex_a;
        id_b_flag   = id_f;
        id_b_addr   = id_a;
        imem_gnt    = (gnt_mode == 1) ? 1'b1 : (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        imem_rvalid = (mq_addr.size() > 0) && (mq_rdy[0] <= cyc);
        imem_rdata  = imem_rvalid ? inst_of(mq_addr[0]) : $urandom;
        #2;
        s_req = imem_req; s_addr = imem_addr; s_pc = if_pc; s_inst = if_inst; s_stallreq = stallreq_if;

        redir = ex_f | id_f;
        tgt   = (ex_f ? ex_a : id_a) & ~32'h3;
        live  = 0;
        foreach (mq_stale[i]) if (!mq_stale[i]) live++;
        exp_empty = (buf_n == 0);
        pop       = !stall_v[1] && !exp_empty && !redir;
        exp_req   = !stall_v[0] && !redir && (mq_addr.size() < DEPTH) &&
                    ((live + buf_n - (pop ? 1 : 0)) < DEPTH);

        checkOutput("imem_req", s_req, exp_req);
        checkOutput("imem_addr", s_addr, exp_fetch);
        checkOutput("stallreq_if", s_stallreq, exp_empty);
        checkOutput("if_pc", s_pc, exp_empty ? 32'h0 : exp_pc);
        checkOutput("if_inst", s_inst, exp_empty ? 32'h0 : inst_of(exp_pc));

        @(posedge clk);
        grant = s_req & imem_gnt;
        if (imem_rvalid) begin
            rsp_stale = mq_stale.pop_front();
            void'(mq_addr.pop_front());
            void'(mq_rdy.pop_front());
            if (!rsp_stale && !redir) buf_n++;
        end
        if (pop) begin
            buf_n--;
            exp_pc += 32'd4;
            n_pops++;
        end
        if (grant) begin
            r = cyc + int'($urandom_range(lat_min, lat_max));
            if (r <= last_rdy) r = last_rdy + 1;
            last_rdy = r;
            mq_addr.push_back(s_addr);
            mq_rdy.push_back(r);
            mq_stale.push_back(1'b0);
            exp_fetch += 32'd4;
        end
        if (redir) begin
            buf_n = 0;
            foreach (mq_stale[i]) mq_stale[i] = 1'b1;
            exp_fetch = tgt;
            exp_pc    = tgt;
        end
        live = 0;
        foreach (mq_stale[i]) if (!mq_stale[i]) live++;
        checkOutput("outstanding_bound", 32'(mq_addr.size() <= DEPTH), 32'd1);
        checkOutput("credit_bound", 32'((live + buf_n) <= DEPTH), 32'd1);
        cyc++;
        ex_f = 1'b0;
        id_f = 1'b0;
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        stall = '0; ex_b_flag = 1'b0; id_b_flag = 1'b0; ex_b_addr = '0; id_b_addr = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        #1;
        checkOutput("rst_imem_req", imem_req, 1'b0);
        checkOutput("rst_imem_addr", imem_addr, RESET_PC);
        checkOutput("rst_if_pc", if_pc, 32'h0);
        checkOutput("rst_if_inst", if_inst, 32'h0);
        checkOutput("rst_stallreq", stallreq_if, 1'b1);
        mq_addr.delete(); mq_rdy.delete(); mq_stale.delete();
        buf_n = 0; last_rdy = cyc; exp_fetch = RESET_PC; exp_pc = RESET_PC;
        ex_f = 1'b0; id_f = 1'b0; stall_v = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic waitHead(input string tag, input int limit);
        for (int k = 0; k < limit && stallreq_if !== 1'b0; k++) applyStimulus();
        checkOutput({tag, "_timeout"}, stallreq_if, 1'b0);
    endtask

    initial begin
        // Reset release: 1-cycle memory, back-to-back fetch
        doReset();
        gnt_mode = 1; lat_min = 1; lat_max = 1;
        applyStimulus();
        checkOutput("first_req", s_req, 1'b1);
        checkOutput("first_addr", s_addr, 32'h100);
        applyStimulus();
        checkOutput("second_addr", s_addr, 32'h104);
        checkOutput("first_if_pc", if_pc, 32'h100);
        checkOutput("first_if_valid", stallreq_if, 1'b0);
        repeat (8) begin
            applyStimulus();
            checkOutput("throughput", s_stallreq, 1'b0);
        end

        // Wait states: no grant for 3 cycles, 2-cycle memory
        doReset();
        gnt_mode = 1; lat_min = 2; lat_max = 2;
        applyStimulus();
        gnt_mode = 0;
        repeat (3) begin
            applyStimulus();
            checkOutput("ws_addr_hold", s_addr, 32'h104);
            checkOutput("ws_req_held", s_req, 1'b1);
        end
        gnt_mode = 1;
        repeat (12) applyStimulus();

        // Head hold with stall[1]
        lat_min = 1; lat_max = 1;
        waitHead("hold_head", 10);
        pc0 = if_pc;
        stall_v = 6'b000010;
        repeat (4) begin
            applyStimulus();
            checkOutput("hold_pc", s_pc, pc0);
        end
        stall_v = '0;
        repeat (6) applyStimulus();

        // Redirect with two live requests in flight
        lat_min = 3; lat_max = 3;
        stall_v = 6'b000001;
        repeat (6) applyStimulus();
        stall_v = '0;
        ex_f = 1'b1; ex_a = 32'h200;
        applyStimulus();
        repeat (2) applyStimulus();
        checkOutput("drop_inflight_n", 32'(mq_addr.size()), 32'd2);
        checkOutput("drop_inflight_a0", mq_addr[0], 32'h200);
        checkOutput("drop_inflight_a1", mq_addr[1], 32'h204);
        ex_f = 1'b1; ex_a = 32'h403;
        applyStimulus();
        for (int k = 0; k < 10; k++) begin
            applyStimulus();
            if (s_req) break;
        end
        checkOutput("redir_req_seen", s_req, 1'b1);
        checkOutput("redir_req_addr", s_addr, 32'h400);
        waitHead("redir_head", 20);
        checkOutput("redir_if_pc", if_pc, 32'h400);

        // EX wins over ID
        lat_min = 1; lat_max = 1;
        ex_f = 1'b1; ex_a = 32'h800;
        id_f = 1'b1; id_a = 32'h900;
        applyStimulus();
        checkOutput("prio_addr", imem_addr, 32'h800);
        waitHead("prio_head", 20);
        checkOutput("prio_if_pc", if_pc, 32'h800);

        // PC wrap at the top of the address space
        id_f = 1'b1; id_a = 32'hFFFF_FFFC;
        applyStimulus();
        waitHead("wrap_head", 20);
        checkOutput("wrap_pc_top", if_pc, 32'hFFFF_FFFC);
        applyStimulus();
        waitHead("wrap_next", 20);
        checkOutput("wrap_pc_zero", if_pc, 32'h0);

        // Asynchronous reset between clock edges, mid-stream
        repeat (5) applyStimulus();
        #2;
        doReset();

        // Randomized traffic
        gnt_mode = 2; lat_min = 1; lat_max = 4;
        n_pops = 0;
        for (int k = 0; k < 1500; k++) begin
            stall_v = {4'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            if ($urandom_range(0, 99) < 3) begin ex_f = 1'b1; ex_a = $urandom; end
            if ($urandom_range(0, 99) < 3) begin id_f = 1'b1; id_a = $urandom; end
            applyStimulus();
        end
        stall_v = '0;
        checkOutput("random_progress", 32'(n_pops >= 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
